// File: rtl/permute_pipe_if.sv
// permute_pipe_if: input/output handshake bundle for permute_pipe.
// dir exists only when PERMUTE_PIPE_BIDIR_EN is defined.
interface permute_pipe_if #(
    parameter int DIM_W   = 1024,
    parameter int SHIFT_W = $clog2(DIM_W)
);
    logic               in_valid;
    logic               in_ready;
    logic [DIM_W-1:0]   data;
    logic [SHIFT_W-1:0] permute_num;
    logic               out_valid;
    logic               out_ready;
    logic [DIM_W-1:0]   result;
    logic [SHIFT_W:0]   inflight;
`ifdef PERMUTE_PIPE_BIDIR_EN
    logic               dir;
`endif

    modport master (
        output in_valid, data, permute_num, out_ready,
`ifdef PERMUTE_PIPE_BIDIR_EN
        output dir,
`endif
        input  in_ready, out_valid, result, inflight
    );

    modport slave (
        input  in_valid, data, permute_num, out_ready,
`ifdef PERMUTE_PIPE_BIDIR_EN
        input  dir,
`endif
        output in_ready, out_valid, result, inflight
    );
endinterface

// File: rtl/permute_pipe.sv
// permute_pipe: log-depth pipelined barrel rotator (stage s rotates by 2^s).
// Define PERMUTE_PIPE_BIDIR_EN to add a per-vector dir bit selecting left rotation.
module permute_pipe #(
    parameter int DIM_W   = 1024,
    parameter int SHIFT_W = $clog2(DIM_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    permute_pipe_if.slave bus
);
    logic               adv;
    logic               in_xfer;
    logic               out_xfer;
    logic [SHIFT_W-1:0] v;
    logic [DIM_W-1:0]   d   [SHIFT_W];
    logic [SHIFT_W-1:0] a   [SHIFT_W];
    logic [DIM_W-1:0]   rot [SHIFT_W];
`ifdef PERMUTE_PIPE_BIDIR_EN
    logic [SHIFT_W-1:0] dr;
`endif

    assign adv           = !v[SHIFT_W-1] || bus.out_ready;
    assign in_xfer       = bus.in_valid && adv;
    assign out_xfer      = v[SHIFT_W-1] && bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v[SHIFT_W-1];
    assign bus.result    = rot[SHIFT_W-1];

    // a[s] holds the amount already shifted down by s, so bit 0 is this stage's bit
    for (genvar s = 0; s < SHIFT_W; s++) begin : g_stage
        localparam int SH = 1 << s;
`ifdef PERMUTE_PIPE_BIDIR_EN
        assign rot[s] = !a[s][0] ? d[s] :
                        dr[s]    ? {d[s][DIM_W-SH-1:0], d[s][DIM_W-1:DIM_W-SH]} :
                                   {d[s][SH-1:0], d[s][DIM_W-1:SH]};
`else
        assign rot[s] = a[s][0] ? {d[s][SH-1:0], d[s][DIM_W-1:SH]} : d[s];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v            <= '0;
            bus.inflight <= '0;
`ifdef PERMUTE_PIPE_BIDIR_EN
            dr           <= '0;
`endif
            for (int i = 0; i < SHIFT_W; i++) begin
                d[i] <= '0;
                a[i] <= '0;
            end
        end else if (clear) begin
            v            <= '0;
            bus.inflight <= '0;
        end else begin
            if (adv) begin
                v    <= {v[SHIFT_W-2:0], bus.in_valid};
                d[0] <= bus.data;
                a[0] <= bus.permute_num;
`ifdef PERMUTE_PIPE_BIDIR_EN
                dr   <= {dr[SHIFT_W-2:0], bus.dir};
`endif
                for (int i = 1; i < SHIFT_W; i++) begin
                    d[i] <= rot[i-1];
                    a[i] <= a[i-1] >> 1;
                end
            end
            bus.inflight <= bus.inflight + (SHIFT_W+1)'(in_xfer) - (SHIFT_W+1)'(out_xfer);
        end
    end
endmodule

// File: tb/tb_permute_pipe.sv
// tb_permute_pipe: randomized and directed checks of permute_pipe against a
// bit-index rotation model with an in-order queue of expected results.
module tb_permute_pipe;
    localparam int DW = 1024;
    localparam int SW = 10;

    logic clk = 0;
    logic rst_n = 0;
    logic clear = 0;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] q[$];

    permute_pipe_if #(.DIM_W(DW), .SHIFT_W(SW)) bus();
    permute_pipe #(.DIM_W(DW), .SHIFT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [DW-1:0] model(logic [DW-1:0] x, int k, bit left);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++)
            r[i] = left ? x[(i - k + DW) % DW] : x[(i + k) % DW];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit cur_dir();
`ifdef PERMUTE_PIPE_BIDIR_EN
        return bus.dir;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: expected results in acceptance order; inflight must equal its depth
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", DW'(bus.out_valid), '0);
            chk("rst_inflight", DW'(bus.inflight), '0);
        end else begin
            chk("inflight", DW'(bus.inflight), DW'(q.size()));
            if (bus.inflight > SW) chk("inflight_max", DW'(bus.inflight), DW'(SW));
            if (!bus.out_valid) chk("in_ready_idle", DW'(bus.in_ready), DW'(1));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 with nothing expected");
                end else chk("result", bus.result, q[0]);
            end
            if (clear) q.delete();
            else begin
                if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
                if (bus.in_valid && bus.in_ready)
                    q.push_back(model(bus.data, int'(bus.permute_num), cur_dir()));
            end
        end
    end

    task automatic drive(bit vld, logic [DW-1:0] x, int k, bit dr);
        bus.in_valid    = vld;
        bus.data        = x;
        bus.permute_num = SW'(k);
`ifdef PERMUTE_PIPE_BIDIR_EN
        bus.dir         = dr;
`else
        if (dr) $display("bidir request ignored");
`endif
    endtask

    task automatic send_one(logic [DW-1:0] x, int k, bit dr, output logic [DW-1:0] res, output int lat);
        drive(1, x, k, dr);
        @(posedge clk); #1;
        drive(0, '0, 0, 0);
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
    endtask

    task automatic idle(int n);
        drive(0, '0, 0, 0);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic count_out(int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (bus.out_valid) cnt++;
        end
    endtask

    initial begin
        logic [DW-1:0] x, y, z, exp;
        int lat, first, last, cnt, peak;
        drive(0, '0, 0, 0);
        bus.out_ready = 1;
        #1;
        chk("reset_out_valid", DW'(bus.out_valid), '0);
        chk("reset_inflight", DW'(bus.inflight), '0);
        chk("reset_result", bus.result, '0);
        chk("reset_in_ready", DW'(bus.in_ready), DW'(1));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        chk("post_reset_in_ready", DW'(bus.in_ready), DW'(1));

        // Pin the model with hand-computed rotations
        exp = '0; exp[DW-1] = 1'b1;
        chk("model_k1", model(DW'(1), 1, 0), exp);
        exp = '0; exp[6] = 1'b1;
        chk("model_k1023", model(DW'(1) << 5, 1023, 0), exp);

        // Single-bit rotate and latency
        send_one(DW'(1), 1, 0, y, lat);
        exp = '0; exp[DW-1] = 1'b1;
        chk("lat_k1", DW'(lat), DW'(SW));
        chk("res_k1", y, exp);
        @(posedge clk); #1;
        chk("one_cycle_valid", DW'(bus.out_valid), '0);

        send_one(DW'(1) << 5, 1023, 0, y, lat);
        exp = '0; exp[6] = 1'b1;
        chk("res_k1023", y, exp);
        x = rnd();
        send_one(x, 0, 0, y, lat);
        chk("identity", y, x);
        chk("lat_k0", DW'(lat), DW'(SW));
        idle(2);

        // Back-to-back stream
        first = -1; last = -1; cnt = 0; peak = 0;
        for (int n = 1; n <= 40; n++) begin
            drive((n - 1) < 20, rnd(), $urandom_range(0, DW-1), 0);
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (first < 0) first = n;
                last = n;
                cnt++;
            end
            if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
        end
        chk("b2b_first", DW'(first), DW'(SW));
        chk("b2b_last", DW'(last), DW'(SW + 19));
        chk("b2b_count", DW'(cnt), DW'(20));
        chk("b2b_peak", DW'(peak), DW'(SW));

        // Backpressure with continuous input
        for (int n = 1; n <= 60; n++) begin
            drive(n <= 40, rnd(), $urandom_range(0, DW-1), 0);
            bus.out_ready = !(n >= 12 && n < 30);
            @(posedge clk); #1;
            if (n == 20) begin
                chk("stall_in_ready", DW'(bus.in_ready), '0);
                chk("stall_inflight", DW'(bus.inflight), DW'(SW));
            end
        end
        bus.out_ready = 1;
        idle(20);
        chk("bp_drained", DW'(q.size()), '0);

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, DW-1), 1'($urandom));
            bus.out_ready = $urandom_range(0, 3) != 0;
            clear = $urandom_range(0, 63) == 0;
            @(posedge clk); #1;
        end
        clear = 0;
        bus.out_ready = 1;
        idle(20);
        chk("rand_drained", DW'(q.size()), '0);

        // Synchronous flush
        for (int n = 0; n < 5; n++) begin
            drive(1, rnd(), $urandom_range(0, DW-1), 0);
            @(posedge clk); #1;
        end
        clear = 1;
        drive(1, rnd(), 3, 0);
        @(posedge clk); #1;
        clear = 0;
        drive(0, '0, 0, 0);
        chk("clear_out_valid", DW'(bus.out_valid), '0);
        chk("clear_inflight", DW'(bus.inflight), '0);
        count_out(15, cnt);
        chk("clear_no_output", DW'(cnt), '0);

        // Asynchronous reset mid-operation
        for (int n = 0; n < 5; n++) begin
            drive(1, rnd(), $urandom_range(0, DW-1), 0);
            @(posedge clk); #1;
        end
        drive(0, '0, 0, 0);
        repeat (6) begin @(posedge clk); #1; end
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", DW'(bus.out_valid), '0);
        chk("arst_inflight", DW'(bus.inflight), '0);
        chk("arst_result", bus.result, '0);
        chk("arst_in_ready", DW'(bus.in_ready), DW'(1));
        @(posedge clk); #1;
        rst_n = 1;
        count_out(15, cnt);
        chk("arst_no_output", DW'(cnt), '0);

`ifdef PERMUTE_PIPE_BIDIR_EN
        x = rnd();
        send_one(x, 37, 0, y, lat);
        chk("bidir_fwd", y, model(x, 37, 0));
        send_one(y, 37, 1, z, lat);
        chk("bidir_inverse", z, x);
`endif
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
